adc128s_serf: RTL and testbench

//  SPI responder (serf) that models the 8-channel, 12-bit ADC128S on the far end of the A2D SPI link.
//  - Accepts 16-bit command frames from the A2D SPI monarch; channel address is in cmd[13:11].
//  - Returns the 12-bit sample of the channel addressed in the PREVIOUS complete frame.
//  - Lives in the bench/FPGA model tier; per-channel sample values are supplied on a flat input bus.

---
 rtl/adc128s_serf.sv | 107 ++++++++++
 tb/tb_adc128s_serf.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/adc128s_serf.sv
// adc128s_serf: SPI responder modelling the 8-channel 12-bit ADC128S; answers each frame with the channel named in the previous good frame.
// Ports: clk/rst_n (async active-low) system clock and reset; SS_n/SCLK/MOSI SPI inputs (SCLK idles high);
// MISO SPI response; ch_data flat per-channel samples; chnnl last good channel address;
// frame_done/frame_err one-clk status pulses; frame_cnt saturating count of good frames.
module adc128s_serf #(
    parameter int DATA_W  = 12,
    parameter int FRAME_W = 16,
    parameter int SYNC_N  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                SCLK,
    input  logic                MOSI,
    output logic                MISO,
    input  logic [8*DATA_W-1:0] ch_data,
    output logic [2:0]          chnnl,
    output logic                frame_done,
    output logic                frame_err,
    output logic [15:0]         frame_cnt
);
    localparam int CW = $clog2(FRAME_W + 2);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    state_t state, state_nxt;

    logic [SYNC_N:0]    sclk_s, ss_s;
    logic [SYNC_N-1:0]  mosi_s;
    logic               sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic               fall_pend, first_fall, good, start;
    logic [FRAME_W-1:0] tx_shft, rx_shft;
    logic [CW-1:0]      rise_cnt;

    // SS_n chain resets to "selected" so a select already low at reset release is not
    // mistaken for a fresh fall; the monarch has to re-assert it.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sclk_s <= '1;
            ss_s   <= '0;
            mosi_s <= '0;
        end else begin
            sclk_s <= {sclk_s[SYNC_N-1:0], SCLK};
            ss_s   <= {ss_s[SYNC_N-1:0], SS_n};
            mosi_s <= {mosi_s[SYNC_N-2:0], MOSI};
        end

    assign sclk_rise = sclk_s[SYNC_N-1] & ~sclk_s[SYNC_N];
    assign sclk_fall = ~sclk_s[SYNC_N-1] & sclk_s[SYNC_N];
    assign ss_rise   = ss_s[SYNC_N-1] & ~ss_s[SYNC_N];
    assign ss_fall   = ~ss_s[SYNC_N-1] & ss_s[SYNC_N];
    assign good      = rise_cnt == CW'(FRAME_W);
    assign start     = state == IDLE && (ss_fall || fall_pend);
    assign MISO      = state == ACTIVE && !ss_s[SYNC_N-1] && tx_shft[FRAME_W-1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        frame_err  = 1'b0;
        case (state)
            IDLE:    state_nxt = start ? ACTIVE : IDLE;
            ACTIVE:  state_nxt = ss_rise ? DONE : ACTIVE;
            DONE: begin
                state_nxt  = IDLE;
                frame_done = good;
                frame_err  = !good || |rx_shft[FRAME_W-1 -: 2] || |rx_shft[FRAME_W-6:0];
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tx_shft    <= '0;
            rx_shft    <= '0;
            rise_cnt   <= '0;
            first_fall <= 1'b0;
            fall_pend  <= 1'b0;
            chnnl      <= '0;
            frame_cnt  <= '0;
        end else begin
            // A select falling during the one-clk DONE state is held for IDLE to pick up.
            fall_pend <= state == DONE && ss_fall;
            if (start) begin
                tx_shft    <= FRAME_W'(ch_data[chnnl*DATA_W +: DATA_W]);
                rise_cnt   <= '0;
                first_fall <= 1'b1;
            end else if (state == ACTIVE && !ss_rise) begin
                if (sclk_rise) begin
                    rx_shft  <= {rx_shft[FRAME_W-2:0], mosi_s[SYNC_N-1]};
                    rise_cnt <= rise_cnt == CW'(FRAME_W + 1) ? rise_cnt : rise_cnt + 1'b1;
                end
                // The first fall only moves SCLK off its idle level; the MSB is already on MISO.
                if (sclk_fall) begin
                    first_fall <= 1'b0;
                    tx_shft    <= first_fall ? tx_shft : tx_shft << 1;
                end
            end
            if (state == DONE && good) begin
                chnnl     <= rx_shft[FRAME_W-3 -: 3];
                frame_cnt <= frame_cnt == 16'hFFFF ? frame_cnt : frame_cnt + 16'd1;
            end
        end
endmodule

// File: tb/tb_adc128s_serf.sv
// tb_adc128s_serf: self-checking bench for adc128s_serf driving SPI frames against a frame-level model.
module tb_adc128s_serf;
    localparam int DW = 12;
    localparam int HP = 8;

    logic          clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, SCLK = 1'b1, MOSI = 1'b0;
    logic [8*DW-1:0] ch_data;
    logic          MISO, frame_done, frame_err;
    logic [2:0]    chnnl;
    logic [15:0]   frame_cnt;

    int errors = 0, checks = 0, n_done = 0, n_err = 0;
    logic [11:0] smp [8];
    logic [2:0]  m_ch;
    int          m_cnt;

    adc128s_serf dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ch_data(ch_data), .chnnl(chnnl), .frame_done(frame_done), .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        ch_data = '0;
        for (int i = 0; i < 8; i++) ch_data[i*DW +: DW] = smp[i];
    end

    always @(negedge clk) begin
        n_done <= n_done + int'(frame_done);
        n_err  <= n_err + int'(frame_err);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        SS_n  = 1'b1;
        SCLK  = 1'b1;
        wait_clk(3);
        check("rst_miso", 32'(MISO), 0);
        check("rst_chnnl", 32'(chnnl), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        check("rst_pulses", 32'({frame_done, frame_err}), 0);
        rst_n = 1'b1;
        wait_clk(4);
        m_ch  = 3'd0;
        m_cnt = 0;
    endtask

    // One SPI transaction of nr SCLK rises; rst_at>0 aborts it with a reset after that rise.
    // scr re-randomises the samples mid-frame: the response must stay the one captured at SS_n fall.
    task automatic frame(input logic [15:0] cmd, input int nr, input int rst_at, input bit scr);
        logic [15:0] resp, expw, mask;
        int d0, e0;
        bit ok;
        resp = '0;
        expw = {4'h0, smp[m_ch]};
        d0 = n_done;
        e0 = n_err;
        SS_n = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < nr; i++) begin
            SCLK = 1'b0;
            MOSI = i < 16 ? cmd[15-i] : 1'b0;
            wait_clk(HP);
            if (i < 16) resp[15-i] = MISO;
            SCLK = 1'b1;
            wait_clk(HP);
            if (scr && i == 0)
                for (int k = 0; k < 8; k++) smp[k] = 12'($urandom);
            if (i + 1 == rst_at) begin
                do_reset();
                return;
            end
        end
        SS_n = 1'b1;
        wait_clk(HP);
        mask = nr >= 16 ? 16'hFFFF : ~(16'hFFFF >> nr);
        ok = nr == 16;
        check("resp", 32'(resp & mask), 32'(expw & mask));
        check("done_pulses", n_done - d0, ok ? 1 : 0);
        check("err_pulses", n_err - e0, (!ok || (cmd & 16'hC7FF) != 0) ? 1 : 0);
        if (ok) begin
            m_ch  = cmd[13:11];
            m_cnt = m_cnt == 16'hFFFF ? m_cnt : m_cnt + 1;
        end
        check("chnnl", 32'(chnnl), 32'(m_ch));
        check("frame_cnt", 32'(frame_cnt), m_cnt);
        check("idle_miso", 32'(MISO), 0);
    endtask

    function automatic logic [15:0] cmd_of(input logic [2:0] ch);
        return {2'b00, ch, 11'd0};
    endfunction

    initial begin
        for (int k = 0; k < 8; k++) smp[k] = 12'($urandom);
        smp[1] = 12'hA5C;
        m_ch = 3'd0;
        m_cnt = 0;
        do_reset();
        frame(16'h0800, 16, 0, 0);
        frame(16'h0800, 16, 0, 0);
        check("t1_chnnl", 32'(chnnl), 1);
        check("t1_cnt", 32'(frame_cnt), 2);
        do_reset();
        frame(16'h2000, 16, 0, 0);
        check("t2_chnnl", 32'(chnnl), 4);
        smp[0] = 12'h111; smp[1] = 12'h222; smp[3] = 12'h333; smp[4] = 12'h444;
        frame(cmd_of(3'd0), 16, 0, 0);
        frame(cmd_of(3'd1), 16, 0, 0);
        frame(cmd_of(3'd3), 16, 0, 0);
        frame(cmd_of(3'd4), 16, 0, 0);
        frame(cmd_of(3'd0), 16, 0, 0);
        frame(cmd_of(3'd6), 9, 0, 0);
        frame(cmd_of(3'd2), 16, 0, 0);
        frame(16'hC800, 16, 0, 0);
        check("t5_chnnl", 32'(chnnl), 1);
        frame(cmd_of(3'd5), 16, 7, 0);
        frame(cmd_of(3'd7), 16, 0, 0);
        frame(cmd_of(3'd7), 16, 0, 1);
        for (int n = 0; n < 30; n++) begin
            logic [15:0] c;
            int nr;
            c = cmd_of(3'($urandom));
            if ($urandom_range(3) == 0) c = c | 16'($urandom) & 16'hC7FF;
            nr = $urandom_range(4) == 0 ? $urandom_range(18, 1) : 16;
            frame(c, nr, 0, $urandom_range(1) == 1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
